// File: rtl/next_pc_ras.sv
// next_pc_ras: owned fetch PC plus return-address stack resolving delayed B, CALL and RET from EX.
// Build macro RAS_CIRCULAR_EN: when defined, a push on a full RAS overwrites the oldest entry instead of being dropped.
module next_pc_ras #(
  parameter int          PC_W      = 16,
  parameter int          OFS_W     = 8,
  parameter int          RAS_DEPTH = 4,
  parameter int          RET_OFS   = 2,
  parameter int          RST_VEC   = 0,
  parameter logic [3:0]  OP_B      = 4'hC,
  parameter logic [3:0]  OP_CALL   = 4'hD,
  parameter logic [3:0]  OP_RET    = 4'hE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           ex_valid,
  input  logic [15:0]                    ex_instr,
  input  logic                           branch,
  output logic [PC_W-1:0]                pc,
  output logic [$clog2(RAS_DEPTH):0]     ras_cnt,
  output logic                           ras_ovf,
  output logic                           ras_unf
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, push;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [3:0]      op;
  logic            full, empty;
  logic [PC_W-1:0] b_tgt, call_tgt, top;
  assign op       = ex_instr[15:12];
  assign full     = cnt_q == CW'(RAS_DEPTH);
  assign empty    = cnt_q == '0;
  assign b_tgt    = pc_q + PC_W'(2) + PC_W'($signed(ex_instr[OFS_W-1:0]));
  assign call_tgt = (pc_q & ~PC_W'(12'hFFF)) | PC_W'(ex_instr[11:0]);
  assign top      = ras_q[ptr_q - AW'(1)];
  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!stall) begin
      pc_d = pc_q + PC_W'(1);
      if (ex_valid && op == OP_B && branch) begin
        pc_d = b_tgt;
      end else if (ex_valid && op == OP_CALL) begin
        pc_d = call_tgt;
        if (full) begin
          ovf_d = 1'b1;
`ifdef RAS_CIRCULAR_EN
          push  = 1'b1;
          ptr_d = ptr_q + AW'(1);
`endif
        end else begin
          push  = 1'b1;
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_q + CW'(1);
        end
      end else if (ex_valid && op == OP_RET) begin
        pc_d  = empty ? pc_q + PC_W'(1) : top;
        ptr_d = empty ? ptr_q : ptr_q - AW'(1);
        cnt_d = empty ? cnt_q : cnt_q - CW'(1);
        unf_d = unf_q | empty;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= PC_W'(RST_VEC);
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // Entry contents need no reset; only ptr/cnt define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[ptr_q] <= pc_q + PC_W'(RET_OFS);
  end
  assign pc      = pc_q;
  assign ras_cnt = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
endmodule

// File: tb/tb_next_pc_ras.sv
// tb_next_pc_ras: directed scoreboard bench for next_pc_ras (expectations follow RAS_CIRCULAR_EN when defined).
module tb_next_pc_ras;
  localparam logic [3:0] OP_B = 4'hC, OP_CALL = 4'hD, OP_RET = 4'hE;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, ex_valid = 1'b0, branch = 1'b0;
  logic [15:0] ex_instr = '0;
  logic [15:0] pc;
  logic [2:0]  ras_cnt;
  logic        ras_ovf, ras_unf;
  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;
  exp_t q[$];
  int   n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  next_pc_ras dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .branch(branch), .pc(pc), .ras_cnt(ras_cnt), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );
  task automatic step(input string name, input logic r, input logic s, input logic v,
                      input logic [3:0] op, input logic [11:0] fld, input logic br,
                      input logic [15:0] epc, input logic [2:0] ecnt, input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; ex_valid = v; ex_instr = {op, fld}; branch = br;
    e.name = name; e.pc = epc; e.cnt = ecnt; e.ovf = eo; e.unf = eu;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_run++;
      if (pc !== e.pc || ras_cnt !== e.cnt || ras_ovf !== e.ovf || ras_unf !== e.unf) begin
        n_fail++;
        $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b, expected pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, pc, ras_cnt, ras_ovf, ras_unf, e.pc, e.cnt, e.ovf, e.unf);
      end
    end
  end
  logic [15:0] ret_exp [5];
  logic [15:0] last_pc;
  initial begin
    step("reset", 1, 0, 0, 4'h0, 12'h000, 0, 16'h0000, 0, 0, 0);
    step("bubble1", 0, 0, 0, OP_CALL, 12'h123, 0, 16'h0001, 0, 0, 0);
    step("bubble2", 0, 0, 0, OP_RET, 12'h000, 0, 16'h0002, 0, 0, 0);
    step("bubble3", 0, 0, 0, OP_B, 12'h010, 1, 16'h0003, 0, 0, 0);
    step("bubble4", 0, 0, 0, 4'h0, 12'h000, 0, 16'h0004, 0, 0, 0);
    step("bubble5", 0, 0, 0, 4'h0, 12'h000, 0, 16'h0005, 0, 0, 0);
    step("ret_empty", 0, 0, 1, OP_RET, 12'h000, 0, 16'h0006, 0, 0, 1);
    step("unf_sticky", 0, 0, 0, 4'h0, 12'h000, 0, 16'h0007, 0, 0, 1);
    step("reset2", 1, 0, 0, 4'h0, 12'h000, 0, 16'h0000, 0, 0, 0);
    step("b_to_40", 0, 0, 1, OP_B, 12'h03E, 1, 16'h0040, 0, 0, 0);
    step("b_fe_taken", 0, 0, 1, OP_B, 12'hFFE, 1, 16'h0040, 0, 0, 0);
    step("b_fe_not", 0, 0, 1, OP_B, 12'h0FE, 0, 16'h0041, 0, 0, 0);
    step("other_op", 0, 0, 1, 4'h0, 12'hFFF, 1, 16'h0042, 0, 0, 0);
    step("reset3", 1, 0, 0, 4'h0, 12'h000, 0, 16'h0000, 0, 0, 0);
    step("b_wrap", 0, 0, 1, OP_B, 12'h080, 1, 16'hFF82, 0, 0, 0);
    step("reset4", 1, 0, 0, 4'h0, 12'h000, 0, 16'h0000, 0, 0, 0);
    for (int i = 1; i <= 95; i++)
      step("b_walk", 0, 0, 1, OP_B, 12'h07F, 1, 16'(i * 129), 0, 0, 0);
    step("b_to_3010", 0, 0, 1, OP_B, 12'h02F, 1, 16'h3010, 0, 0, 0);
    step("call", 0, 0, 1, OP_CALL, 12'h200, 0, 16'h3200, 1, 0, 0);
    step("ret", 0, 0, 1, OP_RET, 12'h000, 0, 16'h3012, 0, 0, 0);
    step("call1", 0, 0, 1, OP_CALL, 12'h100, 0, 16'h3100, 1, 0, 0);
    step("call2", 0, 0, 1, OP_CALL, 12'h200, 0, 16'h3200, 2, 0, 0);
    step("call3", 0, 0, 1, OP_CALL, 12'h300, 0, 16'h3300, 3, 0, 0);
    step("call4", 0, 0, 1, OP_CALL, 12'h400, 0, 16'h3400, 4, 0, 0);
    step("call5_full", 0, 0, 1, OP_CALL, 12'h500, 0, 16'h3500, 4, 1, 0);
`ifdef RAS_CIRCULAR_EN
    ret_exp = '{16'h3402, 16'h3302, 16'h3202, 16'h3102, 16'h3103};
`else
    ret_exp = '{16'h3302, 16'h3202, 16'h3102, 16'h3014, 16'h3015};
`endif
    for (int i = 0; i < 4; i++)
      step("nested_ret", 0, 0, 1, OP_RET, 12'h000, 0, ret_exp[i], 3'(3 - i), 1, 0);
    step("ret_unf", 0, 0, 1, OP_RET, 12'h000, 0, ret_exp[4], 0, 1, 1);
    last_pc = ret_exp[4];
    step("stall_call", 0, 1, 1, OP_CALL, 12'h0AB, 0, last_pc, 0, 1, 1);
    step("stall_bubble", 0, 1, 0, 4'h0, 12'h000, 0, last_pc, 0, 1, 1);
    step("rst_in_stall", 1, 1, 1, OP_CALL, 12'h0AB, 0, 16'h0000, 0, 0, 0);
    step("post_rst_ret", 0, 0, 1, OP_RET, 12'h000, 0, 16'h0001, 0, 0, 1);
    @(negedge clk);
    rst = 0; stall = 1; ex_valid = 0;
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
